res_st_sched: RTL and testbench

Issue scheduler and slot allocator for `res_st`. It tracks which reservation-station entries are busy and which still wait on operand tags, and snoops the common data bus (CDB) to wake waiting entries. It hands free slot addresses to dispatch and picks one ready entry per cycle for the functional unit. On issue it drives the station's read and retire ports.

---
 rtl/qu_common.sv | 10 +
 rtl/rr_prio_enc.sv | 26 ++
 rtl/res_st_sched.sv | 119 +++++++++++
 tb/tb_res_st_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared reservation-station types and constants for the res_st scheduler.
package qu_common;
  localparam int RS_DEPTH_DEFAULT = 32;
  localparam int RES_ST_ADDR_W    = $clog2(RS_DEPTH_DEFAULT);
  typedef logic [RES_ST_ADDR_W-1:0] res_st_addr_t;

  localparam int RS_TAG_W = 5;
  typedef logic [RS_TAG_W-1:0] rs_tag_t;
  localparam rs_tag_t RS_TAG_NONE = '0;
endpackage

// File: rtl/rr_prio_enc.sv
// Priority encoder that searches upward from a start index with wrap-around.
module rr_prio_enc #(
  parameter int W  = 32,
  localparam int IW = $clog2(W)
) (
  input  logic [W-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          found,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] cand;

  // W is a power of two, so the IW-bit add wraps modulo W for free.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < W; i++) begin
      cand = start + IW'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end
endmodule

// File: rtl/res_st_sched.sv
// Slot allocator and issue picker for res_st with CDB wakeup.
// QU_RS_SCHED_RR_EN selects round-robin issue; otherwise lowest-index wins.
module res_st_sched
  import qu_common::*;
#(
  parameter int RES_ST_DEPTH = RS_DEPTH_DEFAULT,
  parameter int TAG_W        = RS_TAG_W,
  localparam int AW = $clog2(RES_ST_DEPTH),
  localparam int OW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [TAG_W-1:0] disp_qk,
  output logic             rs_wr_en,
  output logic [AW-1:0]    rs_wr_addr,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  output logic             iss_valid,
  input  logic             iss_ready,
  output logic [AW-1:0]    iss_addr,
  output logic             rs_retire_en,
  output logic [AW-1:0]    rs_retire_addr,
  output logic [OW-1:0]    occupancy,
  output logic             full,
  output logic             empty
);
  localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(RS_TAG_NONE);

  logic [RES_ST_DEPTH-1:0]            busy_q, busy_d, ready;
  logic [RES_ST_DEPTH-1:0][TAG_W-1:0] tagj_q, tagj_d, tagk_q, tagk_d;
  logic [OW-1:0]                      occ_q, occ_d;
  logic [AW-1:0]                      alloc_idx, iss_start, iss_idx;
  logic                               alloc_found, iss_found;
  logic                               disp_fire, iss_fire, cdb_hit;

  always_comb begin
    for (int i = 0; i < RES_ST_DEPTH; i++)
      ready[i] = busy_q[i] && (tagj_q[i] == TAG_NONE) && (tagk_q[i] == TAG_NONE);
  end

`ifdef QU_RS_SCHED_RR_EN
  logic [AW-1:0] ptr_q, ptr_d;
  assign ptr_d     = iss_fire ? iss_idx + AW'(1) : ptr_q;
  assign iss_start = ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end
`else
  assign iss_start = '0;
`endif

  rr_prio_enc #(.W(RES_ST_DEPTH)) u_alloc_enc (
    .req   (~busy_q),
    .start ('0),
    .found (alloc_found),
    .idx   (alloc_idx)
  );

  rr_prio_enc #(.W(RES_ST_DEPTH)) u_iss_enc (
    .req   (ready),
    .start (iss_start),
    .found (iss_found),
    .idx   (iss_idx)
  );

  assign full       = (occ_q == OW'(RES_ST_DEPTH));
  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;
  assign disp_ready = !full && alloc_found;
  assign iss_valid  = iss_found;
  assign iss_addr   = iss_found ? iss_idx : '0;

  // Reset wins over both handshakes so nothing leaks into res_st during rst.
  assign disp_fire      = disp_valid && disp_ready && !rst;
  assign iss_fire       = iss_valid && iss_ready && !rst;
  assign rs_wr_en       = disp_fire;
  assign rs_wr_addr     = alloc_idx;
  assign rs_retire_en   = iss_fire;
  assign rs_retire_addr = iss_addr;
  assign cdb_hit        = cdb_valid && (cdb_tag != TAG_NONE);

  always_comb begin
    busy_d = busy_q;
    tagj_d = tagj_q;
    tagk_d = tagk_q;
    occ_d  = occ_q + OW'(disp_fire) - OW'(iss_fire);
    for (int i = 0; i < RES_ST_DEPTH; i++) begin
      if (cdb_hit && busy_q[i]) begin
        if (tagj_q[i] == cdb_tag) tagj_d[i] = TAG_NONE;
        if (tagk_q[i] == cdb_tag) tagk_d[i] = TAG_NONE;
      end
    end
    if (iss_fire) busy_d[iss_addr] = 1'b0;
    // Allocated slot is never busy, so it cannot collide with the issued one.
    if (disp_fire) begin
      busy_d[alloc_idx] = 1'b1;
      tagj_d[alloc_idx] = (cdb_hit && disp_qj == cdb_tag) ? TAG_NONE : disp_qj;
      tagk_d[alloc_idx] = (cdb_hit && disp_qk == cdb_tag) ? TAG_NONE : disp_qk;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      tagj_q <= '0;
      tagk_q <= '0;
      occ_q  <= '0;
    end else begin
      busy_q <= busy_d;
      tagj_q <= tagj_d;
      tagk_q <= tagk_d;
      occ_q  <= occ_d;
    end
  end
endmodule

// File: tb/tb_res_st_sched.sv
// Scoreboard bench for res_st_sched: driver pushes model predictions, monitor compares.
module tb_res_st_sched;
  localparam int DEPTH = 32;
  localparam int TW    = 5;
  localparam int AW    = 5;
  localparam int OW    = 6;

  logic          clk = 1'b0;
  logic          rst, disp_valid, disp_ready, rs_wr_en, cdb_valid;
  logic [TW-1:0] disp_qj, disp_qk, cdb_tag;
  logic [AW-1:0] rs_wr_addr, iss_addr, rs_retire_addr;
  logic          iss_valid, iss_ready, rs_retire_en, full, empty;
  logic [OW-1:0] occupancy;

  always #5 clk = ~clk;

  res_st_sched #(.RES_ST_DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_qj(disp_qj), .disp_qk(disp_qk),
    .rs_wr_en(rs_wr_en), .rs_wr_addr(rs_wr_addr),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_addr(iss_addr),
    .rs_retire_en(rs_retire_en), .rs_retire_addr(rs_retire_addr),
    .occupancy(occupancy), .full(full), .empty(empty)
  );

  typedef struct {
    logic dr, fl, em, wen, iv, ren;
    logic [AW-1:0] waddr, ia;
    logic [OW-1:0] occ;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference state: a plain table of station entries.
  bit m_busy[DEPTH];
  int m_tj[DEPTH];
  int m_tk[DEPTH];
  int m_ptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_busy[i] = 0; m_tj[i] = 0; m_tk[i] = 0;
    end
    m_ptr = 0;
  endtask

  task automatic step(input bit dv, input int qj, input int qk, input bit cv,
                      input int ct, input bit ir, input bit r, input bit do_chk);
    exp_t e;
    int   occ, alloc, iss, start, idx;
    @(negedge clk);
    rst = r; disp_valid = dv; disp_qj = TW'(qj); disp_qk = TW'(qk);
    cdb_valid = cv; cdb_tag = TW'(ct); iss_ready = ir;

    occ = 0; alloc = -1; iss = -1;
    for (int i = 0; i < DEPTH; i++) if (m_busy[i]) occ++;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_busy[i]) alloc = i;
`ifdef QU_RS_SCHED_RR_EN
    start = m_ptr;
`else
    start = 0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = (start + k) % DEPTH;
      if (iss < 0 && m_busy[idx] && m_tj[idx] == 0 && m_tk[idx] == 0) iss = idx;
    end

    e.dr    = occ < DEPTH;
    e.fl    = occ == DEPTH;
    e.em    = occ == 0;
    e.occ   = OW'(occ);
    e.wen   = dv && e.dr && !r;
    e.waddr = (alloc >= 0) ? AW'(alloc) : '0;
    e.iv    = iss >= 0;
    e.ia    = e.iv ? AW'(iss) : '0;
    e.ren   = e.iv && ir && !r;
    if (do_chk) q.push_back(e);

    if (r) model_reset();
    else begin
      if (cv && ct != 0)
        for (int i = 0; i < DEPTH; i++)
          if (m_busy[i]) begin
            if (m_tj[i] == ct) m_tj[i] = 0;
            if (m_tk[i] == ct) m_tk[i] = 0;
          end
      if (e.ren) begin
        m_busy[iss] = 0;
        m_ptr = (iss + 1) % DEPTH;
      end
      if (e.wen) begin
        m_busy[alloc] = 1;
        m_tj[alloc] = (cv && ct != 0 && qj == ct) ? 0 : qj;
        m_tk[alloc] = (cv && ct != 0 && qk == ct) ? 0 : qk;
      end
    end
  endtask

  task automatic idle(input bit ir, input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, ir, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        chk("disp_ready", disp_ready, e.dr);
        chk("full", full, e.fl);
        chk("empty", empty, e.em);
        chk("occupancy", occupancy, e.occ);
        chk("rs_wr_en", rs_wr_en, e.wen);
        if (e.wen) chk("rs_wr_addr", rs_wr_addr, e.waddr);
        chk("iss_valid", iss_valid, e.iv);
        chk("iss_addr", iss_addr, e.ia);
        chk("rs_retire_en", rs_retire_en, e.ren);
        if (e.ren) chk("rs_retire_addr", rs_retire_addr, e.ia);
      end
    end
  end

  initial begin : driver
    int qj, qk;
    rst = 1; disp_valid = 0; disp_qj = 0; disp_qk = 0;
    cdb_valid = 0; cdb_tag = 0; iss_ready = 0;
    model_reset();

    // Reset then empty: first cycle state is unknown until the first edge.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 1);
    idle(0, 1);

    // Ready dispatch, then issue.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 2);

    // CDB wakeup and wakeup-on-dispatch.
    step(1, 3, 6, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 3, 1, 0, 1);
    step(0, 0, 0, 1, 6, 1, 0, 1);
    idle(1, 2);
    step(1, 7, 0, 1, 7, 1, 0, 1);
    idle(1, 2);

    // Fill to full, then free one slot and reuse it.
    for (int i = 0; i < DEPTH; i++) step(1, 2, 0, 0, 0, 0, 0, 1);
    step(1, 2, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 2, 0, 0, 1);
    step(1, 4, 0, 0, 0, 1, 0, 1);
    step(1, 4, 0, 0, 0, 0, 0, 1);
    idle(0, 1);
    step(0, 0, 0, 1, 4, 1, 0, 1);
    idle(1, DEPTH + 4);

    // Arbitration: slots 2, 3, 5 ready among blocked neighbours.
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    idle(1, 4);

    // Simultaneous dispatch/issue, then reset alongside a dispatch.
    step(1, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 0, 0, 0, 1, 1, 1);
    idle(0, 2);

    // Randomized traffic with light and heavy issue pressure.
    for (int n = 0; n < 3000; n++) begin
      qj = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(1, 7));
      qk = ($urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 7));
      step($urandom_range(0, 3) != 0, qj, qk, $urandom_range(0, 1) != 0,
           int'($urandom_range(0, 7)),
           (n < 1500) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
           $urandom_range(0, 499) == 0, 1);
    end
    idle(1, 4);

    @(negedge clk);
    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
